// File: rtl/serdes_pkg.sv
// serdes_pkg: shared definitions for serial_frame_deserializer.
//   state_t    : frame decoder states (IDLE, ADDR, DATA, END, DISCARD)
//   ADDR_W_DEF : default address width
//   DATA_W_DEF : default data word width (excluding flag bit)
//   cnt_width  : width of the bit counter that covers both phases
package serdes_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        END,
        DISCARD
    } state_t;

    // $clog2(max(addr_w, data_w + 1) + 1)
    function automatic int cnt_width(input int addr_w, input int data_w);
        int m;
        m = (addr_w > data_w + 1) ? addr_w : data_w + 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_frame_deserializer_bit_shifter.sv
// bit_shifter: serial-in / parallel-out shift register.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (q -> 0)
//   shift_en : shift din in this cycle
//   clear    : zero the register; with shift_en, din lands in an empty register
//   din      : serial input bit
//   q        : parallel contents
// Macro SER_LSB_FIRST_EN: defined -> first received bit ends up in bit 0;
// undefined -> first received bit ends up in bit W-1 (MSB first).
module bit_shifter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         clear,
    input  logic         din,
    output logic [W-1:0] q
);

    logic [W-1:0] base;

    always_comb begin
        base = clear ? '0 : q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
`ifdef SER_LSB_FIRST_EN
            q <= (base >> 1) | (W'(din) << (W - 1));
`else
            q <= (base << 1) | W'(din);
`endif
        end else if (clear) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer: decodes framed serial traffic into
// (address, data word) pairs.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   serin      : serial data line
//   en_1       : address-phase enable
//   en_2       : data-phase enable (DATA_W data bits + 1 flag bit per word)
//   addr_out   : frame address, held until the next address completes
//   data_out   : last completed word, held until the next word
//   word_valid : one-cycle pulse, addr_out/data_out carry a new word
//   last_word  : flag bit of the word, qualified by word_valid
//   frame_done : one-cycle pulse on a clean frame close
//   frame_err  : one-cycle pulse on a framing violation (once per frame)
// Macro SER_LSB_FIRST_EN selects LSB-first bit order (see bit_shifter).
module serial_frame_deserializer
    import serdes_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serin,
    input  logic              en_1,
    input  logic              en_2,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              word_valid,
    output logic              last_word,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int CW = cnt_width(ADDR_W, DATA_W);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              addr_shift, addr_clr, data_shift, data_clr;
    logic              latch_addr, emit_word, done_set, err_set;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;

    bit_shifter #(.W(ADDR_W)) u_addr_shifter (
        .clk      (clk),
        .rst      (rst),
        .shift_en (addr_shift),
        .clear    (addr_clr),
        .din      (serin),
        .q        (addr_sr)
    );

    bit_shifter #(.W(DATA_W)) u_data_shifter (
        .clk      (clk),
        .rst      (rst),
        .shift_en (data_shift),
        .clear    (data_clr),
        .din      (serin),
        .q        (data_sr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (en_2)      state_next = DISCARD;
                else if (en_1) state_next = ADDR;
            end
            ADDR: begin
                if (en_1 && !en_2)      state_next = (cnt == ADDR_LAST) ? DISCARD : ADDR;
                else if (!en_1 && en_2) state_next = (cnt == ADDR_LAST) ? DATA : DISCARD;
                else if (en_1 && en_2)  state_next = DISCARD;
                else                    state_next = IDLE;
            end
            DATA: begin
                if (en_1)                           state_next = DISCARD;
                else if (!en_2)                     state_next = IDLE;
                else if (cnt == DATA_LAST && serin) state_next = END;
            end
            END: begin
                // en_1 arriving as en_2 drops starts the next frame at once
                if (en_2)      state_next = DISCARD;
                else if (en_1) state_next = ADDR;
                else           state_next = IDLE;
            end
            DISCARD: begin
                if (!en_1 && !en_2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath controls; cnt counts bits already received in the current group
    always_comb begin
        cnt_next   = '0;
        addr_shift = 1'b0;
        addr_clr   = 1'b0;
        data_shift = 1'b0;
        data_clr   = 1'b0;
        latch_addr = 1'b0;
        emit_word  = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (en_2) begin
                    err_set = 1'b1;
                end else if (en_1) begin
                    addr_clr   = 1'b1;
                    addr_shift = 1'b1;
                    cnt_next   = ONE;
                end
            end
            ADDR: begin
                if (en_1 && !en_2) begin
                    if (cnt == ADDR_LAST) begin
                        err_set = 1'b1;
                    end else begin
                        addr_shift = 1'b1;
                        cnt_next   = cnt + ONE;
                    end
                end else if (!en_1 && en_2) begin
                    if (cnt == ADDR_LAST) begin
                        latch_addr = 1'b1;
                        data_clr   = 1'b1;
                        data_shift = 1'b1;
                        cnt_next   = ONE;
                    end else begin
                        err_set = 1'b1;
                    end
                end else begin
                    err_set = 1'b1;
                end
            end
            DATA: begin
                if (en_1 || !en_2) begin
                    err_set = 1'b1;
                end else if (cnt == DATA_LAST) begin
                    emit_word = 1'b1;
                end else begin
                    data_shift = 1'b1;
                    cnt_next   = cnt + ONE;
                end
            end
            END: begin
                if (en_2) begin
                    err_set = 1'b1;
                end else begin
                    done_set = 1'b1;
                    if (en_1) begin
                        addr_clr   = 1'b1;
                        addr_shift = 1'b1;
                        cnt_next   = ONE;
                    end
                end
            end
            DISCARD: begin
            end
            default: begin
            end
        endcase
    end

    // Counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            addr_out   <= '0;
            data_out   <= '0;
            word_valid <= 1'b0;
            last_word  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            word_valid <= emit_word;
            last_word  <= emit_word & serin;
            frame_done <= done_set;
            frame_err  <= err_set;
            if (latch_addr) addr_out <= addr_sr;
            if (emit_word)  data_out <= data_sr;
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer (default parameters).
// Honours SER_LSB_FIRST_EN when compiled with it.
module tb_serial_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst, serin, en_1, en_2;
    logic [5:0] addr_out;
    logic [3:0] data_out;
    logic       word_valid, last_word, frame_done, frame_err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int err_cnt    = 0;
    int done_cnt   = 0;
    int word_cnt   = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;

    typedef struct {
        logic [5:0] addr;
        logic [3:0] data;
        logic       last;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [5:0] addr;
        logic [3:0] w0;
        logic [3:0] w1;
        int         nw;
        logic [5:0] exp_addr;
        logic [3:0] exp_data;
        int         exp_gap;
    } vec_t;
    vec_t vecs[5];

    serial_frame_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .serin      (serin),
        .en_1       (en_1),
        .en_2       (en_2),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .word_valid (word_valid),
        .last_word  (last_word),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bit order seen at the outputs for a value sent MSB first on the wire
    function automatic logic [5:0] xa(input logic [5:0] a);
        logic [5:0] r;
`ifdef SER_LSB_FIRST_EN
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
`else
        r = a;
`endif
        return r;
    endfunction

    function automatic logic [3:0] xd(input logic [3:0] d);
        logic [3:0] r;
`ifdef SER_LSB_FIRST_EN
        for (int i = 0; i < 4; i++) r[i] = d[3-i];
`else
        r = d;
`endif
        return r;
    endfunction

    // Monitor: samples 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        err_cnt  += int'(frame_err);
        done_cnt += int'(frame_done);
        if (word_valid) begin
            word_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_word_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word_addr", 32'(addr_out), 32'(e.addr));
                check("word_data", 32'(data_out), 32'(e.data));
                check("word_last", 32'(last_word), 32'(e.last));
            end
        end
    end

    task automatic drive(input logic r, input logic e1, input logic e2, input logic s);
        @(negedge clk);
        rst = r; en_1 = e1; en_2 = e2; serin = s;
    endtask

    task automatic send_addr(input logic [5:0] a, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, 1'b1, 1'b0, (i < 6) ? a[5-i] : 1'b0);
        end
    endtask

    task automatic send_word(input logic [3:0] w, input logic flag, input logic [5:0] ea);
        exp_t e;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, w[3-i]);
        drive(1'b0, 1'b0, 1'b1, flag);
        e.addr = ea; e.data = xd(w); e.last = flag;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int e0, d0, w0c;
    logic [3:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'h2D, 4'hA, 4'h0, 1, 6'h2D, 4'hA, 0};
        vecs[1] = '{6'h2D, 4'h3, 4'hC, 2, 6'h2D, 4'hC, 5};
        vecs[2] = '{6'h00, 4'h0, 4'h0, 1, 6'h00, 4'h0, 0};
        vecs[3] = '{6'h3F, 4'hF, 4'hF, 2, 6'h3F, 4'hF, 5};
        vecs[4] = '{6'h15, 4'h9, 4'h6, 2, 6'h15, 4'h6, 5};

        rst = 1'b1; en_1 = 1'b0; en_2 = 1'b0; serin = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_addr_out", 32'(addr_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_last_word", 32'(last_word), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        idle(2);

        // Table-driven good frames
        for (int v = 0; v < 5; v++) begin
            e0 = err_cnt; d0 = done_cnt;
            send_addr(vecs[v].addr, 6);
            if (vecs[v].nw == 1) begin
                send_word(vecs[v].w0, 1'b1, xa(vecs[v].addr));
            end else begin
                send_word(vecs[v].w0, 1'b0, xa(vecs[v].addr));
                send_word(vecs[v].w1, 1'b1, xa(vecs[v].addr));
            end
            idle(3);
            check("vec_done", 32'(done_cnt - d0), 32'd1);
            check("vec_err", 32'(err_cnt - e0), 32'd0);
            check("vec_addr_out", 32'(addr_out), 32'(xa(vecs[v].exp_addr)));
            check("vec_data_out", 32'(data_out), 32'(xd(vecs[v].exp_data)));
            if (vecs[v].nw == 2)
                check("vec_word_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'(vecs[v].exp_gap));
        end

        // Short address (5 bits) then data phase
        e0 = err_cnt; w0c = word_cnt;
        send_addr(6'h2D, 5);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        check("short_addr_err", 32'(err_cnt - e0), 32'd1);
        check("short_addr_no_word", 32'(word_cnt - w0c), 32'd0);

        // Good frame after the discarded one
        d0 = done_cnt;
        send_addr(6'h12, 6);
        send_word(4'h5, 1'b1, xa(6'h12));
        idle(3);
        check("recover_done", 32'(done_cnt - d0), 32'd1);

        // Partial word: en_2 drops after 3 data bits
        held = data_out;
        e0 = err_cnt; w0c = word_cnt;
        send_addr(6'h0B, 6);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        check("partial_err", 32'(err_cnt - e0), 32'd1);
        check("partial_no_word", 32'(word_cnt - w0c), 32'd0);
        check("partial_data_held", 32'(data_out), 32'(held));
        check("partial_addr_latched", 32'(addr_out), 32'(xa(6'h0B)));

        // Reset during the second data bit
        e0 = err_cnt; d0 = done_cnt;
        send_addr(6'h33, 6);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_addr_out", 32'(addr_out), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_word_valid", 32'(word_valid), 32'd0);
        idle(2);
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        send_addr(6'h2D, 6);
        send_word(4'hA, 1'b1, xa(6'h2D));
        idle(3);
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);
        check("post_rst_data", 32'(data_out), 32'(xd(4'hA)));

        // Back-to-back frames: new en_1 as END sees en_2 fall
        e0 = err_cnt; d0 = done_cnt;
        send_addr(6'h21, 6);
        send_word(4'h7, 1'b1, xa(6'h21));
        send_addr(6'h1E, 6);
        send_word(4'hB, 1'b1, xa(6'h1E));
        idle(3);
        check("b2b_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_err", 32'(err_cnt - e0), 32'd0);
        check("b2b_addr", 32'(addr_out), 32'(xa(6'h1E)));

        // Extra bit after flag
        e0 = err_cnt; d0 = done_cnt;
        send_addr(6'h0F, 6);
        send_word(4'h4, 1'b1, xa(6'h0F));
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("extra_bit_err", 32'(err_cnt - e0), 32'd1);
        check("extra_bit_no_done", 32'(done_cnt - d0), 32'd0);

        // Address too long
        e0 = err_cnt;
        send_addr(6'h2A, 7);
        idle(3);
        check("long_addr_err", 32'(err_cnt - e0), 32'd1);

        // Data phase straight out of IDLE
        e0 = err_cnt;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        check("idle_en2_err", 32'(err_cnt - e0), 32'd1);

        idle(4);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
- Downstream consumer of the serial framing controller.
- Takes the raw serial line `serin` plus the controller's phase enables: `en_1` marks the address phase, `en_2` marks the data phase.
- Shifts address bits and data bits into registers and emits parallel (address, data word) pairs with a one-cycle valid pulse.
- Flags malformed frames so the sink can drop them.

Parameters:
- ADDR_W, 6, number of address bits per frame, one bit per en_1 cycle.
- DATA_W, 4, data bits per word. Each word is followed by one flag bit, so each en_2 group is DATA_W+1 bits.

Ports:
- clk  input  1  system clock; all sampling on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serin  input  1  serial data line.
- en_1  input  1  address-phase enable from the framing controller.
- en_2  input  1  data-phase enable from the framing controller.
- addr_out  output  ADDR_W  address of the current frame; held until the next frame's address completes.
- data_out  output  DATA_W  last completed data word; held until the next word.
- word_valid  output  1  one-cycle pulse: addr_out/data_out carry a new word.
- last_word  output  1  qualified by word_valid; 1 = flag bit was 1, so this word ends the frame.
- frame_done  output  1  one-cycle pulse when a frame closes cleanly.
- frame_err  output  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset (`rst` high at a rising clk edge): all outputs 0, shift registers 0, bit counter 0, state IDLE. Reset mid-frame discards everything; no pulses are emitted for the aborted frame.
- `en_1`/`en_2` change on the falling clk edge upstream. This block samples `serin`/`en_*` on the rising edge only. Bits are MSB first.
- Counter width is $clog2(max(ADDR_W, DATA_W+1)+1).
- State IDLE:
  - en_1=1, en_2=0 -> ADDR; shift the first bit; cnt=1.
  - en_2=1 (any en_1) -> DISCARD; frame_err pulse.
- State ADDR:
  - en_1=1, en_2=0 -> shift serin, cnt++.
  - If cnt would exceed ADDR_W -> DISCARD with frame_err.
  - en_1=0, en_2=1 with cnt==ADDR_W -> latch addr_out; go to DATA; shift the first data bit; cnt=1.
  - en_1=0, en_2=1 with cnt!=ADDR_W -> DISCARD with frame_err.
  - Both low, or both high -> IDLE (both low) or DISCARD (both high), with frame_err.
- State DATA, while en_2=1:
  - cnt in 1..DATA_W: shift serin into the data shift register.
  - cnt==DATA_W+1: this bit is the flag.
  - At the rising edge sampling the flag, in the following cycle:
    - data_out = shifted word; last_word = flag; word_valid=1 for exactly one cycle.
    - cnt resets to 0.
    - flag=1 -> state END.
  - en_2 falls with cnt!=0 (partial word) -> frame_err; partial word dropped; IDLE.
  - en_2 falls with cnt==0 and no flag=1 seen -> frame_err; IDLE.
  - en_1=1 in DATA -> DISCARD with frame_err.
- State END:
  - en_2=0 -> frame_done pulse; IDLE.
  - en_2 still 1 (bit beyond flag) -> frame_err; DISCARD.
- State DISCARD: ignore serin until en_1=0 and en_2=0, then IDLE. No word_valid is ever raised in DISCARD.
- frame_err is raised at most once per frame.
- A new en_1 in the same cycle END sees en_2 fall: emit frame_done and enter ADDR directly, first address bit shifted. No lost bit.
- Latency: word_valid appears one clk after the rising edge that sampled the flag bit.

Optional Feature:
- SER_LSB_FIRST_EN defined: address and data bits are shifted LSB first (first received bit lands in bit 0). The flag bit position is unchanged.
- Not defined: MSB first, as above.

Decomposition:
- Shared package `serdes_pkg`: state enum (IDLE, ADDR, DATA, END, DISCARD), ADDR_W/DATA_W defaults, counter-width function.
- One natural sub-module `bit_shifter`: parameterised width, shift-enable, clear, direction selected by SER_LSB_FIRST_EN. Instantiated twice, for address and data.

Test Plan:
1. Address 101101, one word 1010 with flag 1, en_2 then falls -> addr_out=6'h2D, data_out=4'hA, last_word=1, word_valid one cycle, then frame_done; frame_err never high.
2. Same address, words 0011 (flag 0) then 1100 (flag 1) -> two word_valid pulses exactly 5 clks apart, data 4'h3 then 4'hC, last_word 0 then 1.
3. en_1 held for 5 cycles only, then en_2 -> frame_err pulse; no word_valid until after en_1 and en_2 are both low and a good frame follows.
4. en_2 drops after 3 data bits -> frame_err; data_out keeps its previous value; state returns to IDLE.
5. rst asserted during the 2nd data bit -> all outputs 0 next cycle; a following good frame decodes correctly.
6. With SER_LSB_FIRST_EN, stimulus of test 1 -> addr_out=6'h2D bit-reversed=6'h2D, data_out=4'h5.
